// File: rtl/uart_frame_tx.sv
// ----------------------------------------------------------------------------
// uart_frame_tx
//   UART frame transmitter. On a start request it latches an N-byte word and
//   sends it MSB byte first, then TRAIL_BYTES copies of TRAIL_CHAR. The 8N1/8N2
//   serialiser, baud timing and the power-up quiet period are all built in, so
//   the block drives the board TXD pin directly.
//
//   Optional build macro:
//     UART_FRAME_HEX_ASCII_EN  each payload byte goes out as two upper-case
//                              ASCII hex characters, high nibble first. The
//                              trailer characters are unchanged. When the macro
//                              is not defined, payload bytes are sent raw.
//
// Ports
//   uartclk   in   1             sole clock, rising edge
//   rst_n     in   1             asynchronous active-low reset
//   gosen     in   1             start request, sampled every cycle
//   rddata    in   8*DATA_BYTES  payload, captured only on the accepting cycle
//   txd       out  1             UART serial output, idle high (registered)
//   busy      out  1             high from accept to frame end, and in startup
//   uartdone  out  1             one-cycle pulse when the last stop bit ends
// ----------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BYTES   = 8,
    parameter int unsigned TRAIL_BYTES  = 2,
    parameter logic [7:0]  TRAIL_CHAR   = 8'h0A,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned STARTUP_CLKS = 200000
) (
    input  logic                    uartclk,
    input  logic                    rst_n,
    input  logic                    gosen,
    input  logic [8*DATA_BYTES-1:0] rddata,
    output logic                    txd,
    output logic                    busy,
    output logic                    uartdone
);

`ifdef UART_FRAME_HEX_ASCII_EN
    localparam int unsigned CHARS_PER_BYTE = 2;
`else
    localparam int unsigned CHARS_PER_BYTE = 1;
`endif
    // Payload bits consumed per payload character.
    localparam int unsigned CHAR_SHIFT = 8 / CHARS_PER_BYTE;
    localparam int unsigned NPAY       = DATA_BYTES * CHARS_PER_BYTE;
    localparam int unsigned NCH        = NPAY + TRAIL_BYTES;
    localparam int unsigned CW         = $clog2(NCH + 1);
    localparam int unsigned PW         = 8 * DATA_BYTES;
    localparam int unsigned TMAX       = (CLKS_PER_BIT > STARTUP_CLKS) ? CLKS_PER_BIT : STARTUP_CLKS;
    localparam int unsigned TW         = $clog2(TMAX + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    // A zero startup period still spends one cycle in STARTUP.
    localparam logic [TW-1:0] SU_LAST   = TW'((STARTUP_CLKS > 0) ? STARTUP_CLKS - 1 : 0);
    localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);
    localparam logic [CW-1:0] CH_NPAY   = CW'(NPAY);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    // Elaboration-time parameter guards.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_frame_tx: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_frame_tx: STOP_BITS must be 1 or 2");
        end
        if (DATA_BYTES < 1) begin : g_bad_bytes
            $error("uart_frame_tx: DATA_BYTES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t          state,    state_nx;
    logic [TW-1:0]   timer,    timer_nx;
    logic [2:0]      bit_idx,  bit_nx;
    logic            stop_idx, stop_nx;
    logic [CW-1:0]   char_idx, char_nx;
    logic [PW-1:0]   shreg,    shreg_nx;
    logic            txd_nx;
    logic            busy_nx;
    logic            done_nx;
    logic            bit_end;
    logic [7:0]      cur_char;

`ifdef UART_FRAME_HEX_ASCII_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction
`endif

    // Character currently on the wire. Payload characters are always taken
    // from the top of the shift register, which advances at each payload
    // character boundary; the trailer follows once the payload is used up.
    always_comb begin
        cur_char = TRAIL_CHAR;
        if (char_idx < CH_NPAY) begin
`ifdef UART_FRAME_HEX_ASCII_EN
            cur_char = hex_ascii(shreg[PW-1 -: 4]);
`else
            cur_char = shreg[PW-1 -: 8];
`endif
        end
    end

    always_ff @(posedge uartclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STARTUP;
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            char_idx <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b1;
            uartdone <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            bit_idx  <= bit_nx;
            stop_idx <= stop_nx;
            char_idx <= char_nx;
            shreg    <= shreg_nx;
            txd      <= txd_nx;
            busy     <= busy_nx;
            uartdone <= done_nx;
        end
    end

    // txd is registered, so every transition computes the line level of the
    // bit period that begins at this edge, not the one that is ending.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        bit_nx   = bit_idx;
        stop_nx  = stop_idx;
        char_nx  = char_idx;
        shreg_nx = shreg;
        txd_nx   = txd;
        busy_nx  = busy;
        done_nx  = 1'b0;
        bit_end  = (timer == BIT_LAST);

        case (state)
            ST_STARTUP: begin
                txd_nx  = 1'b1;
                busy_nx = 1'b1;
                if (timer == SU_LAST) begin
                    state_nx = ST_IDLE;
                    timer_nx = '0;
                    busy_nx  = 1'b0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            ST_IDLE: begin
                txd_nx  = 1'b1;
                busy_nx = 1'b0;
                if (gosen) begin
                    state_nx = ST_START;
                    timer_nx = '0;
                    bit_nx   = '0;
                    stop_nx  = 1'b0;
                    char_nx  = '0;
                    shreg_nx = rddata;
                    txd_nx   = 1'b0;
                    busy_nx  = 1'b1;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_nx = ST_DATA;
                    timer_nx = '0;
                    bit_nx   = '0;
                    txd_nx   = cur_char[0];
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    timer_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = ST_STOP;
                        stop_nx  = 1'b0;
                        txd_nx   = 1'b1;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                        txd_nx = cur_char[bit_idx + 3'd1];
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    timer_nx = '0;
                    if (stop_idx != STOP_LAST) begin
                        stop_nx = 1'b1;
                    end else begin
                        if (char_idx < CH_NPAY) begin
                            shreg_nx = shreg << CHAR_SHIFT;
                        end
                        if (char_idx == CH_LAST) begin
                            state_nx = ST_DONE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            txd_nx   = 1'b1;
                        end else begin
                            state_nx = ST_START;
                            char_nx  = char_idx + 1'b1;
                            txd_nx   = 1'b0;
                        end
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
                txd_nx   = 1'b1;
                busy_nx  = 1'b0;
            end

            default: begin
                state_nx = ST_STARTUP;
                timer_nx = '0;
                txd_nx   = 1'b1;
                busy_nx  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_tx
//   Directed bench for uart_frame_tx with CLKS_PER_BIT=4, STARTUP_CLKS=16,
//   DATA_BYTES=8, TRAIL_BYTES=2. A second instance with STOP_BITS=2 shares
//   the inputs and is only examined in the two-stop-bit scenario.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_frame_tx;
    localparam int CPB = 4;
    localparam int SU  = 16;

    logic        uartclk = 1'b0;
    logic        rst_n;
    logic        gosen;
    logic [63:0] rddata;
    logic        txd,  busy,  uartdone;
    logic        txd2, busy2, uartdone2;
    logic        sel;
    logic        m_txd, m_busy, m_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [7:0] exp_chars [0:31];
    int         exp_n;
    logic [7:0] hexc [0:15] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    always #5 uartclk = ~uartclk;

    assign m_txd  = sel ? txd2      : txd;
    assign m_busy = sel ? busy2     : busy;
    assign m_done = sel ? uartdone2 : uartdone;

    always @(posedge uartclk) begin
        if (uartdone === 1'b1) done_cnt <= done_cnt + 1;
    end

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BYTES   (8),
        .TRAIL_BYTES  (2),
        .TRAIL_CHAR   (8'h0A),
        .STOP_BITS    (1),
        .STARTUP_CLKS (SU)
    ) dut (
        .uartclk  (uartclk),
        .rst_n    (rst_n),
        .gosen    (gosen),
        .rddata   (rddata),
        .txd      (txd),
        .busy     (busy),
        .uartdone (uartdone)
    );

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BYTES   (8),
        .TRAIL_BYTES  (2),
        .TRAIL_CHAR   (8'h0A),
        .STOP_BITS    (2),
        .STARTUP_CLKS (SU)
    ) dut2 (
        .uartclk  (uartclk),
        .rst_n    (rst_n),
        .gosen    (gosen),
        .rddata   (rddata),
        .txd      (txd2),
        .busy     (busy2),
        .uartdone (uartdone2)
    );

    task automatic tick();
        @(posedge uartclk);
        #1;
    endtask

    // Expected character list for a payload word plus the two 0x0A trailers.
    task automatic build_exp(input logic [63:0] v);
        logic [7:0] b;
        exp_n = 0;
        for (int i = 7; i >= 0; i--) begin
            b = v[8*i +: 8];
`ifdef UART_FRAME_HEX_ASCII_EN
            exp_chars[exp_n] = hexc[b[7:4]];
            exp_n++;
            exp_chars[exp_n] = hexc[b[3:0]];
            exp_n++;
`else
            exp_chars[exp_n] = b;
            exp_n++;
`endif
        end
        exp_chars[exp_n] = 8'h0A;
        exp_n++;
        exp_chars[exp_n] = 8'h0A;
        exp_n++;
    endtask

    // Called one step after the accept edge. Decodes every character cycle by
    // cycle, optionally pulsing gosen or changing rddata at a character start,
    // and returns one step after the DONE-entry edge.
    task automatic rx_frame(input string name, input int sb, input int pulse_char,
                            input int rd_char, input logic [63:0] rd_val);
        logic [7:0] c;
        logic       first;
        int         bad_frame;
        int         bad_busy;
        bad_busy = 0;
        first    = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            c         = '0;
            bad_frame = 0;
            for (int b = 0; b < 9 + sb; b++) begin
                for (int j = 0; j < CPB; j++) begin
                    if (j == 0 && b == 0 && i == pulse_char) gosen = 1'b1;
                    if (j == 0 && b == 0 && i == rd_char) rddata = rd_val;
                    if (j == 0) first = m_txd;
                    else if (m_txd !== first) bad_frame++;
                    if (m_busy !== 1'b1 || m_done !== 1'b0) bad_busy++;
                    tick();
                    if (j == 0 && b == 0 && i == pulse_char) gosen = 1'b0;
                end
                if (b == 0) begin
                    if (first !== 1'b0) bad_frame++;
                end else if (b <= 8) begin
                    c[b-1] = first;
                end else if (first !== 1'b1) begin
                    bad_frame++;
                end
            end
            checks++;
            if (c !== exp_chars[i]) begin
                failures++;
                $display("FAIL %s char%0d value: got %h expected %h", name, i, c, exp_chars[i]);
            end
            checks++;
            if (bad_frame != 0) begin
                failures++;
                $display("FAIL %s char%0d framing: got %0d bad samples expected 0", name, i, bad_frame);
            end
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL %s busy_in_frame: got %0d bad samples expected 0", name, bad_busy);
        end
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_txd !== 1'b1) begin
            failures++;
            $display("FAIL %s done_cycle: got done=%b busy=%b txd=%b expected 1 0 1",
                     name, m_done, m_busy, m_txd);
        end
    endtask

    // Reset values, startup quiet period with gosen high, accept on first IDLE cycle.
    task automatic test_reset();
        int n_busy;
        int quiet_bad;
        rst_n  = 1'b0;
        gosen  = 1'b1;
        sel    = 1'b0;
        rddata = 64'h4142_4344_4546_4748;
        tick();
        tick();
        checks++;
        if (txd !== 1'b1 || busy !== 1'b1 || uartdone !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got txd=%b busy=%b done=%b expected 1 1 0", txd, busy, uartdone);
        end
        rst_n     = 1'b1;
        n_busy    = 0;
        quiet_bad = 0;
        while (busy === 1'b1 && n_busy < 100) begin
            if (txd !== 1'b1) quiet_bad++;
            n_busy++;
            tick();
        end
        checks++;
        if (n_busy != SU) begin
            failures++;
            $display("FAIL startup_len: got %0d busy cycles expected %0d", n_busy, SU);
        end
        checks++;
        if (quiet_bad != 0 || txd !== 1'b1) begin
            failures++;
            $display("FAIL startup_quiet: got %0d low samples txd=%b expected 0 and 1", quiet_bad, txd);
        end
        tick();
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_accept: got txd=%b busy=%b expected 0 1", txd, busy);
        end
    endtask

    // Decodes the frame accepted at the end of test_reset.
    task automatic test_frame();
        int d0;
        d0 = done_cnt;
        build_exp(64'h4142_4344_4546_4748);
        rx_frame("frame1", 1, -1, -1, 64'h0);
        gosen = 1'b0;
        tick();
        checks++;
        if (done_cnt - d0 != 1 || uartdone !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL frame1_done_once: got %0d pulses done=%b busy=%b expected 1 0 0",
                     done_cnt - d0, uartdone, busy);
        end
    endtask

    // gosen pulses at char 3 and in the DONE cycle are dropped.
    task automatic test_ignore();
        int d0;
        int hi_bad;
        d0     = done_cnt;
        rddata = 64'h0123_4567_89AB_CDEF;
        build_exp(64'h0123_4567_89AB_CDEF);
        gosen  = 1'b1;
        tick();
        gosen  = 1'b0;
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL ignore_accept: got txd=%b expected 0", txd);
        end
        rx_frame("ignore", 1, 3, -1, 64'h0);
        gosen = 1'b1;
        tick();
        gosen  = 1'b0;
        hi_bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (txd !== 1'b1 || busy !== 1'b0) hi_bad++;
            tick();
        end
        checks++;
        if (hi_bad != 0) begin
            failures++;
            $display("FAIL ignore_done_pulse: got %0d non-idle samples expected 0", hi_bad);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0);
        end
    endtask

    // gosen held for three frames; rddata changes while each frame is in flight.
    task automatic test_back_to_back();
        logic [63:0] vals [0:3];
        int d0;
        vals[0] = 64'hA1B2_C3D4_E5F6_0718;
        vals[1] = 64'h5566_7788_99AA_BBCC;
        vals[2] = 64'h0F1E_2D3C_4B5A_6978;
        vals[3] = 64'hFFFF_0000_FFFF_0000;
        d0     = done_cnt;
        rddata = vals[0];
        gosen  = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (txd !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_accept%0d: got txd=%b busy=%b expected 0 1", f, txd, busy);
            end
            build_exp(vals[f]);
            rddata = 64'hDEAD_BEEF_DEAD_BEEF;
            rx_frame($sformatf("b2b%0d", f), 1, -1, 4, vals[f+1]);
            if (f == 2) gosen = 1'b0;
            tick();
            checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || uartdone !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle%0d: got txd=%b busy=%b done=%b expected 1 0 0",
                         f, txd, busy, uartdone);
            end
            tick();
        end
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || done_cnt - d0 != 3) begin
            failures++;
            $display("FAIL b2b_end: got txd=%b busy=%b pulses=%0d expected 1 0 3",
                     txd, busy, done_cnt - d0);
        end
    endtask

    // Reset asserted at char 5 data bit 3, then quiet period and a clean frame.
    task automatic test_midreset();
        int d0;
        int n_busy;
        int quiet_bad;
        rddata = 64'h4142_4344_4546_4748;
        build_exp(64'h4142_4344_4546_4748);
        gosen = 1'b1;
        tick();
        gosen = 1'b0;
        d0    = done_cnt;
        repeat (5*40 + 4 + 3*CPB) tick();
        checks++;
        if (txd !== exp_chars[5][3]) begin
            failures++;
            $display("FAIL midreset_prebit: got %b expected %b", txd, exp_chars[5][3]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b1 || uartdone !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: got txd=%b busy=%b done=%b expected 1 1 0", txd, busy, uartdone);
        end
        tick();
        tick();
        rst_n     = 1'b1;
        n_busy    = 0;
        quiet_bad = 0;
        while (busy === 1'b1 && n_busy < 100) begin
            if (txd !== 1'b1) quiet_bad++;
            n_busy++;
            tick();
        end
        checks++;
        if (n_busy != SU || quiet_bad != 0 || done_cnt != d0) begin
            failures++;
            $display("FAIL midreset_quiet: got len=%0d low=%0d pulses=%0d expected %0d 0 0",
                     n_busy, quiet_bad, done_cnt - d0, SU);
        end
        rddata = 64'h3132_3334_3536_3738;
        build_exp(64'h3132_3334_3536_3738);
        gosen = 1'b1;
        tick();
        gosen = 1'b0;
        rx_frame("midreset_clean", 1, -1, -1, 64'h0);
        tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL midreset_done_count: got %0d expected 1", done_cnt - d0);
        end
    endtask

    // Mixed-nibble payload on the 1-stop instance, then the 2-stop instance.
    task automatic test_stop2();
        int w;
        rst_n = 1'b0;
        gosen = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (SU) tick();
        rddata = 64'h00FF_1A2B_3C4D_5E6F;
        build_exp(64'h00FF_1A2B_3C4D_5E6F);
        gosen = 1'b1;
        tick();
        gosen = 1'b0;
        sel   = 1'b0;
        rx_frame("stop1_mixed", 1, -1, -1, 64'h0);
        checks++;
        if (busy2 !== 1'b1 || uartdone2 !== 1'b0) begin
            failures++;
            $display("FAIL stop2_still_busy: got busy=%b done=%b expected 1 0", busy2, uartdone2);
        end
        w = 0;
        while (uartdone2 !== 1'b1 && w < 1000) begin
            tick();
            w++;
        end
        checks++;
        if (w != exp_n * CPB) begin
            failures++;
            $display("FAIL stop2_extra_len: got %0d cycles expected %0d", w, exp_n * CPB);
        end
        tick();
        gosen = 1'b1;
        tick();
        gosen = 1'b0;
        sel   = 1'b1;
        rx_frame("stop2", 2, -1, -1, 64'h0);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ignore();
        test_back_to_back();
        test_midreset();
        test_stop2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
